program_loader: RTL and testbench

Host-side boot and run controller that sits directly upstream of the 5-stage RISC-V core. It accepts a program as a valid/ready word stream, writes it into the core's instruction memory via the core's `wr_im`/`top_inst_i` write port, pulses `start`, then supervises execution. It counts run cycles and retired instructions until the core raises `finish`, or until a timeout.

---
 rtl/program_loader.sv | 169 ++++++++++++++++
 tb/tb_program_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot/run controller for the 5-stage RISC-V core: streams a program into IM, pulses start, supervises the run.
// Optional feature: define PROGRAM_LOADER_RETIRE_CNT_EN to include the retired-instruction counter.
module program_loader #(
    parameter int unsigned MAX_WORDS  = 1024,
    parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        clear,
    output logic        cpu_wr_im,
    output logic [31:0] cpu_inst,
    output logic        cpu_start,
    input  logic        cpu_finish,
    input  logic [31:0] cpu_executed_inst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [10:0] word_count,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
);

    localparam logic [10:0] WORD_LIMIT = 11'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        wr_nxt;
    logic [31:0] inst_nxt;
    logic [10:0] wc_nxt;
    logic [31:0] cc_nxt;
    logic [1:0]  ec_nxt;
    logic        ready_nxt;
    logic        start_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic        error_nxt;

    assign accept = s_valid && s_ready;

    always_comb begin
        state_nxt = state;
        wr_nxt    = 1'b0;
        inst_nxt  = cpu_inst;
        wc_nxt    = word_count;
        cc_nxt    = cycle_count;
        ec_nxt    = err_code;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    wr_nxt    = 1'b1;
                    inst_nxt  = s_data;
                    wc_nxt    = 11'd1;
                    cc_nxt    = 32'd0;
                    state_nxt = s_last ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    // A full IM drops the word instead of overwriting address 0.
                    if (word_count == WORD_LIMIT) begin
                        state_nxt = S_ERR;
                        ec_nxt    = 2'd1;
                    end else begin
                        wr_nxt    = 1'b1;
                        inst_nxt  = s_data;
                        wc_nxt    = word_count + 11'd1;
                        if (s_last) begin
                            state_nxt = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN: begin
                if (cpu_finish) begin
                    state_nxt = S_DONE;
                end else if (cycle_count == MAX_CYCLES) begin
                    state_nxt = S_ERR;
                    ec_nxt    = 2'd2;
                end else begin
                    cc_nxt = cycle_count + 32'd1;
                end
            end
            S_DONE, S_ERR: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                    ec_nxt    = 2'd0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they align with it.
        ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
        start_nxt = (state_nxt == S_START);
        busy_nxt  = (state_nxt == S_LOAD) || (state_nxt == S_FLUSH) ||
                    (state_nxt == S_START) || (state_nxt == S_RUN);
        done_nxt  = (state_nxt == S_DONE);
        error_nxt = (state_nxt == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            s_ready     <= 1'b1;
            cpu_wr_im   <= 1'b0;
            cpu_inst    <= 32'd0;
            cpu_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            word_count  <= 11'd0;
            cycle_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            s_ready     <= ready_nxt;
            cpu_wr_im   <= wr_nxt;
            cpu_inst    <= inst_nxt;
            cpu_start   <= start_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
            err_code    <= ec_nxt;
            word_count  <= wc_nxt;
            cycle_count <= cc_nxt;
        end
    end

`ifdef PROGRAM_LOADER_RETIRE_CNT_EN
    logic [31:0] retired_q;

    // Zero on the executed-instruction bus marks a bubble or flushed slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 32'd0;
        end else if (state == S_IDLE && accept) begin
            retired_q <= 32'd0;
        end else if (state == S_RUN && !cpu_finish && cpu_executed_inst != 32'd0) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_count = retired_q;
`else
    logic unused_executed;
    assign unused_executed = ^cpu_executed_inst;
    assign retired_count   = 32'd0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scoreboarded IM writes plus per-scenario control/counter checks.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        s_last = 1'b0;
    logic        clear = 1'b0;
    logic        cpu_finish = 1'b0;
    logic [31:0] cpu_executed_inst = 32'd0;

    logic        s_ready, cpu_wr_im, cpu_start, busy, done, error;
    logic [31:0] cpu_inst, cycle_count, retired_count;
    logic [1:0]  err_code;
    logic [10:0] word_count;

    logic        t_s_ready, t_cpu_wr_im, t_cpu_start, t_busy, t_done, t_error;
    logic [31:0] t_cpu_inst, t_cycle_count, t_retired_count;
    logic [1:0]  t_err_code;
    logic [10:0] t_word_count;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

`ifdef PROGRAM_LOADER_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    program_loader #(.MAX_WORDS(4), .MAX_CYCLES(32'd100)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .clear(clear), .cpu_wr_im(cpu_wr_im), .cpu_inst(cpu_inst),
        .cpu_start(cpu_start), .cpu_finish(cpu_finish), .cpu_executed_inst(cpu_executed_inst),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .word_count(word_count), .cycle_count(cycle_count), .retired_count(retired_count)
    );

    program_loader #(.MAX_WORDS(1024), .MAX_CYCLES(32'd8)) dut_t (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(t_s_ready), .s_data(s_data),
        .s_last(s_last), .clear(clear), .cpu_wr_im(t_cpu_wr_im), .cpu_inst(t_cpu_inst),
        .cpu_start(t_cpu_start), .cpu_finish(cpu_finish), .cpu_executed_inst(cpu_executed_inst),
        .busy(t_busy), .done(t_done), .error(t_error), .err_code(t_err_code),
        .word_count(t_word_count), .cycle_count(t_cycle_count), .retired_count(t_retired_count)
    );

    // Scoreboard: every IM write must match the oldest expected word, in order.
    always @(negedge clk) begin
        if (cpu_wr_im === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: cpu_inst=%h written, no word expected", cpu_inst);
            end else begin
                exp_w = exp_q.pop_front();
                if (cpu_inst !== exp_w) $display("FAIL wr_data: cpu_inst=%h expected %h", cpu_inst, exp_w);
                else n_pass++;
            end
        end
        if (cpu_start === 1'b1) begin
            n_checks++;
            if (cpu_wr_im !== 1'b0) $display("FAIL start_vs_wr: cpu_wr_im=%b expected 0 during start", cpu_wr_im);
            else n_pass++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; clear = 1'b0;
        cpu_finish = 1'b0; cpu_executed_inst = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input bit exp_wr);
        s_valid = 1'b1; s_data = d; s_last = last;
        if (exp_wr) exp_q.push_back(d);
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_data = 32'hDEAD_BEEF;
    endtask

    // Drives n RUN cycles (3 of every 5 non-bubble), then one finish cycle.
    task automatic run_prog(input int n, output int nz);
        nz = 0;
        for (int i = 0; i < n; i++) begin
            cpu_finish = 1'b0;
            cpu_executed_inst = (i % 5 < 3) ? 32'h0000_0013 + i : 32'd0;
            if (cpu_executed_inst != 32'd0) nz++;
            @(posedge clk); #1;
        end
        cpu_finish = 1'b1; cpu_executed_inst = 32'h0000_0033;
        @(posedge clk); #1;
        cpu_finish = 1'b0; cpu_executed_inst = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_data = 32'h1234_5678; s_last = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_ready, cpu_wr_im, cpu_start, busy, done, error, err_code} !== 8'b1000_0000)
            $display("FAIL reset_ctrl: got %b expected 10000000",
                     {s_ready, cpu_wr_im, cpu_start, busy, done, error, err_code});
        else n_pass++;
        n_checks++;
        if (cpu_inst !== 32'd0) $display("FAIL reset_inst: got %h expected 0", cpu_inst);
        else n_pass++;
        n_checks++;
        if ({word_count, cycle_count, retired_count} !== 75'd0)
            $display("FAIL reset_counts: wc=%0d cc=%0d rc=%0d expected 0", word_count, cycle_count, retired_count);
        else n_pass++;
        n_checks++;
        if ({t_s_ready, t_cpu_wr_im, t_cpu_start, t_busy, t_done, t_error, t_err_code} !== 8'b1000_0000)
            $display("FAIL reset_ctrl_t: got %b expected 10000000",
                     {t_s_ready, t_cpu_wr_im, t_cpu_start, t_busy, t_done, t_error, t_err_code});
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load4();
        do_reset();
        send_word(32'h0050_0093, 1'b0, 1'b1);
        send_word(32'h0060_0113, 1'b0, 1'b1);
        send_word(32'h0020_81B3, 1'b0, 1'b1);
        send_word(32'h0000_0013, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({s_ready, busy, cpu_start, cpu_wr_im} !== 4'b0101)
            $display("FAIL load_flush: {s_ready,busy,start,wr}=%b expected 0101", {s_ready, busy, cpu_start, cpu_wr_im});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({cpu_start, cpu_wr_im} !== 2'b10)
            $display("FAIL load_start: {start,wr}=%b expected 10", {cpu_start, cpu_wr_im});
        else n_pass++;
        n_checks++;
        if (word_count !== 11'd4) $display("FAIL load_wc: got %0d expected 4", word_count);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL load_pending: %0d words not written", exp_q.size());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_run_finish();
        int exp_ret = 0;
        for (int i = 0; i < 20; i++) begin
            cpu_finish = 1'b0;
            cpu_executed_inst = (i % 5 < 3) ? 32'h0000_0013 + i : 32'd0;
            if (cpu_executed_inst != 32'd0) exp_ret++;
            if (i == 0) begin
                @(negedge clk);
                n_checks++;
                if ({cpu_start, busy} !== 2'b01) $display("FAIL run_entry: {start,busy}=%b expected 01", {cpu_start, busy});
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        cpu_finish = 1'b1; cpu_executed_inst = 32'h0000_0033;
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b01) $display("FAIL done_early: {done,busy}=%b expected 01", {done, busy});
        else n_pass++;
        @(posedge clk); #1;
        cpu_finish = 1'b0; cpu_executed_inst = 32'd0;
        @(negedge clk);
        n_checks++;
        if ({done, busy, error} !== 3'b100) $display("FAIL run_done: {done,busy,error}=%b expected 100", {done, busy, error});
        else n_pass++;
        n_checks++;
        if (cycle_count !== 32'd20) $display("FAIL run_cycles: got %0d expected 20", cycle_count);
        else n_pass++;
        n_checks++;
        if (retired_count !== (RET_EN ? 32'(exp_ret) : 32'd0))
            $display("FAIL run_retired: got %0d expected %0d", retired_count, RET_EN ? exp_ret : 0);
        else n_pass++;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_ready, done, word_count, cycle_count} !== {1'b1, 1'b0, 11'd4, 32'd20})
            $display("FAIL done_clear: s_ready=%b done=%b wc=%0d cc=%0d expected 1 0 4 20",
                     s_ready, done, word_count, cycle_count);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) send_word(32'h0000_1000 + i, 1'b0, i < 4);
        @(negedge clk);
        n_checks++;
        if ({error, err_code, s_ready, busy} !== 5'b10100)
            $display("FAIL ovf_state: {error,code,ready,busy}=%b expected 10100", {error, err_code, s_ready, busy});
        else n_pass++;
        n_checks++;
        if (word_count !== 11'd4) $display("FAIL ovf_wc: got %0d expected 4", word_count);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL ovf_pending: %0d words not written", exp_q.size());
        else n_pass++;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({error, err_code, s_ready, word_count} !== {1'b0, 2'd0, 1'b1, 11'd4})
            $display("FAIL ovf_clear: error=%b code=%0d ready=%b wc=%0d expected 0 0 1 4",
                     error, err_code, s_ready, word_count);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int cyc = 1;
        do_reset();
        send_word(32'h0000_0013, 1'b1, 1'b1);
        while (t_error !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc !== 12) $display("FAIL to_latency: error after %0d cycles expected 12", cyc);
        else n_pass++;
        n_checks++;
        if ({t_err_code, t_busy, t_cycle_count} !== {2'd2, 1'b0, 32'd8})
            $display("FAIL to_state: code=%0d busy=%b cc=%0d expected 2 0 8", t_err_code, t_busy, t_cycle_count);
        else n_pass++;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({t_s_ready, t_error, t_err_code, t_cycle_count} !== {1'b1, 1'b0, 2'd0, 32'd8})
            $display("FAIL to_clear: ready=%b error=%b code=%0d cc=%0d expected 1 0 0 8",
                     t_s_ready, t_error, t_err_code, t_cycle_count);
        else n_pass++;
        n_checks++;
        if ({busy, done, error} !== 3'b100)
            $display("FAIL clear_in_run: {busy,done,error}=%b expected 100", {busy, done, error});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int nz;
        do_reset();
        send_word(32'h0000_0093, 1'b0, 1'b1);
        send_word(32'h0000_0113, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_ready, cpu_wr_im, cpu_start, busy, done, error, err_code, cpu_inst, word_count} !==
            {8'b1000_0000, 32'd0, 11'd0})
            $display("FAIL rst_load: ctrl=%b inst=%h wc=%0d expected 10000000 0 0",
                     {s_ready, cpu_wr_im, cpu_start, busy, done, error, err_code}, cpu_inst, word_count);
        else n_pass++;
        @(posedge clk); #1;
        send_word(32'h00A0_0093, 1'b1, 1'b1);
        cpu_executed_inst = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cpu_executed_inst = 32'd0;
        @(negedge clk);
        n_checks++;
        if ({s_ready, cpu_wr_im, cpu_start, busy, done, error, err_code, cycle_count, retired_count, word_count} !==
            {8'b1000_0000, 32'd0, 32'd0, 11'd0})
            $display("FAIL rst_run: ctrl=%b cc=%0d rc=%0d wc=%0d expected 10000000 0 0 0",
                     {s_ready, cpu_wr_im, cpu_start, busy, done, error, err_code},
                     cycle_count, retired_count, word_count);
        else n_pass++;
        @(posedge clk); #1;
        send_word(32'h0010_0073, 1'b1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        run_prog(5, nz);
        @(negedge clk);
        n_checks++;
        if ({done, error, word_count, cycle_count} !== {1'b1, 1'b0, 11'd1, 32'd5})
            $display("FAIL rst_reload: done=%b error=%b wc=%0d cc=%0d expected 1 0 1 5",
                     done, error, word_count, cycle_count);
        else n_pass++;
        n_checks++;
        if (retired_count !== (RET_EN ? 32'(nz) : 32'd0))
            $display("FAIL rst_retired: got %0d expected %0d", retired_count, RET_EN ? nz : 0);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_gaps();
        int nz;
        do_reset();
        send_word(32'h0000_0A01, 1'b0, 1'b1);
        @(posedge clk); #1;
        send_word(32'h0000_0A02, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        send_word(32'h0000_0A03, 1'b1, 1'b1);
        // Offered while s_ready is low: must not be written.
        send_word(32'h0000_0BAD, 1'b1, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, error} !== 3'b100)
            $display("FAIL gap_clear_run: {busy,done,error}=%b expected 100", {busy, done, error});
        else n_pass++;
        run_prog(2, nz);
        @(negedge clk);
        n_checks++;
        if ({done, word_count, cycle_count} !== {1'b1, 11'd3, 32'd6})
            $display("FAIL gap_done: done=%b wc=%0d cc=%0d expected 1 3 6", done, word_count, cycle_count);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL gap_pending: %0d words not written", exp_q.size());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load4();
        test_run_finish();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_gaps();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
